// File: rtl/scan_chain_master_if.sv
// Pin bundle between the scan-chain driver and the two-phase scan chain it serves.
interface scan_chain_master_if;
  logic clk1;
  logic clk2;
  logic scan_in;
  logic capture;
  logic update;
  logic scan_out;

  modport master (output clk1, clk2, scan_in, capture, update, input scan_out);
  modport slave  (input clk1, clk2, scan_in, capture, update, output scan_out);
endinterface

// File: rtl/scan_chain_master.sv
// Serialises a parallel word into a two-phase (clk1/clk2) scan chain and collects scan_out back.
// Optional: define SCAN_MASTER_LOOPBACK_CHECK_EN to add the chk_err shift-twice integrity flag.
module scan_chain_master #(
  parameter int unsigned NUM_SCAN_BITS = 523,
  parameter int unsigned PHASE         = 1,
  parameter int unsigned CNT_W         = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     do_capture,
  input  logic                     do_update,
  input  logic [NUM_SCAN_BITS-1:0] wr_data,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_SCAN_BITS-1:0] rd_data,
`ifdef SCAN_MASTER_LOOPBACK_CHECK_EN
  output logic                     chk_err,
`endif
  scan_chain_master_if.master      scan
);

  localparam int unsigned TMR_W = $clog2(4 * PHASE) + 1;
  localparam logic [TMR_W-1:0] PH_LAST  = TMR_W'(PHASE - 1);
  localparam logic [TMR_W-1:0] CAP_LAST = TMR_W'(4 * PHASE - 1);
  localparam logic [TMR_W-1:0] SUB1     = TMR_W'(PHASE);
  localparam logic [TMR_W-1:0] SUB2     = TMR_W'(2 * PHASE);
  localparam logic [TMR_W-1:0] SUB3     = TMR_W'(3 * PHASE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SCAN_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CAP, S_SETUP, S_C1, S_GAP, S_C2, S_UPD, S_DONE
  } state_t;

  state_t                   state, state_n;
  logic [TMR_W-1:0]         tmr, tmr_n, tmr_inc;
  logic [CNT_W-1:0]         cnt, cnt_n;
  logic [NUM_SCAN_BITS-1:0] wr_sh, wr_sh_n, rd_sh, rd_sh_n, rd_data_n;
  logic                     cap_req, cap_req_n, upd_req, upd_req_n;
  logic                     busy_n, done_n;
  logic                     clk1_q, clk1_n, clk2_q, clk2_n, scan_in_q, scan_in_n;
  logic                     capture_q, capture_n, update_q, update_n;
  logic                     ph_end;
`ifdef SCAN_MASTER_LOOPBACK_CHECK_EN
  logic [NUM_SCAN_BITS-1:0] cur_wr, cur_wr_n, prev_wr, prev_wr_n;
  logic                     have_prev, have_prev_n, chk_err_n;
`endif

  assign scan.clk1    = clk1_q;
  assign scan.clk2    = clk2_q;
  assign scan.scan_in = scan_in_q;
  assign scan.capture = capture_q;
  assign scan.update  = update_q;

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tmr       <= '0;
      cnt       <= '0;
      wr_sh     <= '0;
      rd_sh     <= '0;
      cap_req   <= 1'b0;
      upd_req   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_data   <= '0;
      clk1_q    <= 1'b0;
      clk2_q    <= 1'b0;
      scan_in_q <= 1'b0;
      capture_q <= 1'b0;
      update_q  <= 1'b0;
`ifdef SCAN_MASTER_LOOPBACK_CHECK_EN
      cur_wr    <= '0;
      prev_wr   <= '0;
      have_prev <= 1'b0;
      chk_err   <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      tmr       <= tmr_n;
      cnt       <= cnt_n;
      wr_sh     <= wr_sh_n;
      rd_sh     <= rd_sh_n;
      cap_req   <= cap_req_n;
      upd_req   <= upd_req_n;
      busy      <= busy_n;
      done      <= done_n;
      rd_data   <= rd_data_n;
      clk1_q    <= clk1_n;
      clk2_q    <= clk2_n;
      scan_in_q <= scan_in_n;
      capture_q <= capture_n;
      update_q  <= update_n;
`ifdef SCAN_MASTER_LOOPBACK_CHECK_EN
      cur_wr    <= cur_wr_n;
      prev_wr   <= prev_wr_n;
      have_prev <= have_prev_n;
      chk_err   <= chk_err_n;
`endif
    end
  end

  // Next state; outputs are decoded from the next state so they register cleanly
  always_comb begin
    state_n   = state;
    tmr_n     = tmr;
    cnt_n     = cnt;
    wr_sh_n   = wr_sh;
    rd_sh_n   = rd_sh;
    cap_req_n = cap_req;
    upd_req_n = upd_req;
    tmr_inc   = tmr + TMR_W'(1);
    ph_end    = (tmr == PH_LAST);
`ifdef SCAN_MASTER_LOOPBACK_CHECK_EN
    cur_wr_n    = cur_wr;
    prev_wr_n   = prev_wr;
    have_prev_n = have_prev;
    chk_err_n   = chk_err;
`endif

    unique case (state)
      S_IDLE: begin
        if (start) begin
          wr_sh_n   = wr_data;
          cap_req_n = do_capture;
          upd_req_n = do_update;
          cnt_n     = '0;
          tmr_n     = '0;
          state_n   = do_capture ? S_CAP : S_SETUP;
`ifdef SCAN_MASTER_LOOPBACK_CHECK_EN
          cur_wr_n  = wr_data;
          chk_err_n = 1'b0;
`endif
        end
      end
      S_CAP: begin
        tmr_n = tmr_inc;
        if (tmr == CAP_LAST) begin
          tmr_n   = '0;
          state_n = S_SETUP;
        end
      end
      S_SETUP: begin
        tmr_n = tmr_inc;
        if (ph_end) begin
          rd_sh_n = {scan.scan_out, rd_sh[NUM_SCAN_BITS-1:1]};
          tmr_n   = '0;
          state_n = S_C1;
        end
      end
      S_C1: begin
        tmr_n = tmr_inc;
        if (ph_end) begin
          tmr_n   = '0;
          state_n = S_GAP;
        end
      end
      S_GAP: begin
        tmr_n = tmr_inc;
        if (ph_end) begin
          tmr_n   = '0;
          state_n = S_C2;
        end
      end
      S_C2: begin
        tmr_n = tmr_inc;
        if (ph_end) begin
          tmr_n   = '0;
          wr_sh_n = {1'b0, wr_sh[NUM_SCAN_BITS-1:1]};
          cnt_n   = cnt + CNT_W'(1);
          if (cnt == CNT_LAST) state_n = upd_req ? S_UPD : S_DONE;
          else                 state_n = S_SETUP;
        end
      end
      S_UPD: begin
        tmr_n = tmr_inc;
        if (ph_end) begin
          tmr_n   = '0;
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        tmr_n   = '0;
        state_n = S_IDLE;
      end
      default: begin
        tmr_n   = '0;
        state_n = S_IDLE;
      end
    endcase

    busy_n    = (state_n != S_IDLE) && (state_n != S_DONE);
    done_n    = (state_n == S_DONE);
    capture_n = (state_n == S_CAP);
    update_n  = (state_n == S_UPD);
    clk1_n    = (state_n == S_C1) || (capture_n && (tmr_n >= SUB1) && (tmr_n < SUB2));
    clk2_n    = (state_n == S_C2) || (capture_n && (tmr_n >= SUB3));

    // scan_in holds between bits and only moves while both clocks are low
    scan_in_n = scan_in_q;
    if (state_n == S_IDLE)       scan_in_n = 1'b0;
    else if (state_n == S_SETUP) scan_in_n = wr_sh_n[0];

    rd_data_n = (state_n == S_DONE) ? rd_sh_n : rd_data;

`ifdef SCAN_MASTER_LOOPBACK_CHECK_EN
    if (state_n == S_DONE) begin
      chk_err_n   = have_prev && (rd_sh_n != prev_wr);
      prev_wr_n   = cur_wr;
      have_prev_n = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_scan_chain_master.sv
// Bench for scan_chain_master: two DUTs (PHASE=1 and PHASE=3) each driving a behavioural scan chain.
module tb_scan_chain_master;
  localparam int N = 8;

  typedef struct {
    int         d;
    logic       cap;
    logic       upd;
    logic       pre_en;
    logic [7:0] pre;
    logic [7:0] par;
    logic [7:0] wd;
    logic [7:0] exp_rd;
    int         exp_lat;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst, start, do_cap, do_upd;
  logic [N-1:0] wr_data [2];
  wire  [1:0] busy, done;
  wire  [N-1:0] rd_data0, rd_data1;
  wire  [1:0] clk1, clk2, scan_in, capture, update;
`ifdef SCAN_MASTER_LOOPBACK_CHECK_EN
  wire  [1:0] chk_err;
`endif

  logic [N-1:0] chain [2];
  logic [N-1:0] master [2];
  logic [N-1:0] shadow [2];
  logic [N-1:0] par_in [2];
  logic [N-1:0] ld_val [2];
  logic [N-1:0] si_seq [2];
  logic [1:0]   ld_req, mon_clr;
  logic [1:0]   p1, p2, psi;
  int viol [2], upd_cyc [2], cap_cyc [2], cap_clks [2], run1 [2], run2 [2];
  logic [N-1:0] exp_chain [2];

  int checks = 0;
  int failures = 0;

  scan_chain_master_if sif0 ();
  scan_chain_master_if sif1 ();

  scan_chain_master #(.NUM_SCAN_BITS(N), .PHASE(1), .CNT_W(4)) u_dut0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .do_capture(do_cap[0]), .do_update(do_upd[0]),
    .wr_data(wr_data[0]), .busy(busy[0]), .done(done[0]), .rd_data(rd_data0),
`ifdef SCAN_MASTER_LOOPBACK_CHECK_EN
    .chk_err(chk_err[0]),
`endif
    .scan(sif0.master)
  );

  scan_chain_master #(.NUM_SCAN_BITS(N), .PHASE(3), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .do_capture(do_cap[1]), .do_update(do_upd[1]),
    .wr_data(wr_data[1]), .busy(busy[1]), .done(done[1]), .rd_data(rd_data1),
`ifdef SCAN_MASTER_LOOPBACK_CHECK_EN
    .chk_err(chk_err[1]),
`endif
    .scan(sif1.master)
  );

  assign clk1    = {sif1.clk1, sif0.clk1};
  assign clk2    = {sif1.clk2, sif0.clk2};
  assign scan_in = {sif1.scan_in, sif0.scan_in};
  assign capture = {sif1.capture, sif0.capture};
  assign update  = {sif1.update, sif0.update};
  assign sif0.scan_out = chain[0][0];
  assign sif1.scan_out = chain[1][0];

  function automatic int ph_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [N-1:0] rd_of(input int d);
    return (d == 0) ? rd_data0 : rd_data1;
  endfunction

  // Master/slave chain model plus protocol monitors
  always @(posedge clk) begin
    int v;
    for (int d = 0; d < 2; d++) begin
      if (ld_req[d])    chain[d] <= ld_val[d];
      else if (clk2[d]) chain[d] <= master[d];
      if (clk1[d]) master[d] <= capture[d] ? par_in[d] : {scan_in[d], chain[d][N-1:1]};
      if (update[d]) shadow[d] <= chain[d];

      v = 0;
      if (clk1[d] && clk2[d]) v++;
      if ((scan_in[d] != psi[d]) && ((clk1[d] && !p1[d]) || (clk2[d] && !p2[d]) || clk1[d])) v++;
      if (!clk1[d] && p1[d] && run1[d] != ph_of(d)) v++;
      if (!clk2[d] && p2[d] && run2[d] != ph_of(d)) v++;
      p1[d] <= clk1[d];
      p2[d] <= clk2[d];
      psi[d] <= scan_in[d];
      if (mon_clr[d]) begin
        viol[d] <= 0; upd_cyc[d] <= 0; cap_cyc[d] <= 0; cap_clks[d] <= 0;
        run1[d] <= 0; run2[d] <= 0; si_seq[d] <= '0;
      end else begin
        viol[d]    <= viol[d] + v;
        upd_cyc[d] <= upd_cyc[d] + 32'(update[d]);
        cap_cyc[d] <= cap_cyc[d] + 32'(capture[d]);
        cap_clks[d] <= cap_clks[d] + 32'(capture[d] && ((clk1[d] && !p1[d]) || (clk2[d] && !p2[d])));
        run1[d] <= clk1[d] ? run1[d] + 1 : 0;
        run2[d] <= clk2[d] ? run2[d] + 1 : 0;
        if (clk1[d] && !p1[d] && !capture[d]) si_seq[d] <= {scan_in[d], si_seq[d][N-1:1]};
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Starts an operation at a negedge and returns at the negedge of the DONE cycle
  task automatic run_op(input int d, input logic cap, input logic upd, input logic [N-1:0] wd,
                        input logic poke, output int lat);
    do_cap[d] = cap; do_upd[d] = upd; wr_data[d] = wd; start[d] = 1'b1; mon_clr[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0; mon_clr[d] = 1'b0; wr_data[d] = ~wd;
    lat = 1;
    check("busy_after_start", 32'(busy[d]), 32'd1);
    while (!done[d] && lat < 600) begin
      if (poke && lat == 10) begin start[d] = 1'b1; do_cap[d] = ~cap; end
      else if (poke && lat == 11) start[d] = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!done[d]) check("done_timeout", 32'd0, 32'd1);
    check("busy_at_done", 32'(busy[d]), 32'd0);
  endtask

  task automatic do_vec(input vec_t v, input logic poke);
    int lat;
    int ph;
    logic [N-1:0] old_sh;
    ph = ph_of(v.d);
    @(negedge clk);
    par_in[v.d] = v.par;
    if (v.pre_en) begin
      ld_val[v.d] = v.pre; ld_req[v.d] = 1'b1;
      @(negedge clk);
      ld_req[v.d] = 1'b0;
    end
    old_sh = shadow[v.d];
    run_op(v.d, v.cap, v.upd, v.wd, poke, lat);
    check("latency", 32'(lat), 32'(v.exp_lat));
    check("rd_data", 32'(rd_of(v.d)), 32'(v.exp_rd));
    check("chain_loaded", 32'(chain[v.d]), 32'(v.wd));
    check("shadow", 32'(shadow[v.d]), 32'(v.upd ? v.wd : old_sh));
    check("update_cycles", 32'(upd_cyc[v.d]), v.upd ? 32'(ph) : 32'd0);
    check("capture_cycles", 32'(cap_cyc[v.d]), v.cap ? 32'(4 * ph) : 32'd0);
    check("capture_clk_pulses", 32'(cap_clks[v.d]), v.cap ? 32'd2 : 32'd0);
    check("scan_in_sequence", 32'(si_seq[v.d]), 32'(v.wd));
    check("protocol_invariants", 32'(viol[v.d]), 32'd0);
    exp_chain[v.d] = v.wd;
  endtask

  function automatic vec_t rand_vec(input int d);
    vec_t v;
    int ph;
    ph = ph_of(d);
    v.d = d; v.cap = 1'($urandom); v.upd = 1'($urandom); v.pre_en = 1'b0; v.pre = '0;
    v.par = 8'($urandom); v.wd = 8'($urandom);
    v.exp_rd  = v.cap ? v.par : exp_chain[d];
    v.exp_lat = (v.cap ? 4 * ph : 0) + 4 * ph * N + (v.upd ? ph : 0) + 1;
    return v;
  endfunction

  vec_t vecs [5];

  initial begin
    vec_t rv;
    vecs[0] = '{0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'hA5, 8'h00, 34};
    vecs[1] = '{0, 1'b0, 1'b0, 1'b1, 8'h3C, 8'h00, 8'h11, 8'h3C, 33};
    vecs[2] = '{0, 1'b1, 1'b0, 1'b1, 8'h55, 8'hF0, 8'h00, 8'hF0, 37};
    vecs[3] = '{1, 1'b0, 1'b1, 1'b1, 8'h0F, 8'h00, 8'h81, 8'h0F, 100};
    vecs[4] = '{1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h69, 8'hC3, 8'h69, 112};

    rst = 2'b11; start = '0; do_cap = '0; do_upd = '0; wr_data[0] = '0; wr_data[1] = '0;
    mon_clr = 2'b11; ld_req = 2'b11; ld_val[0] = '0; ld_val[1] = '0; par_in[0] = '0; par_in[1] = '0;
    exp_chain[0] = '0; exp_chain[1] = '0;
    repeat (3) @(negedge clk);
    rst = '0; ld_req = '0; mon_clr = '0;
    for (int d = 0; d < 2; d++) begin
      check("reset_busy", 32'(busy[d]), 32'd0);
      check("reset_done", 32'(done[d]), 32'd0);
      check("reset_rd_data", 32'(rd_of(d)), 32'd0);
      check("reset_scan_pins", 32'({clk1[d], clk2[d], scan_in[d], capture[d], update[d]}), 32'd0);
    end

    for (int i = 0; i < 5; i++) do_vec(vecs[i], 1'b0);

    for (int i = 0; i < 12; i++) begin
      rv = rand_vec(int'($urandom_range(0, 1)));
      do_vec(rv, 1'b0);
    end

    // start while busy, then start held through the DONE cycle
    rv = rand_vec(0);
    do_vec(rv, 1'b1);
    start[0] = 1'b1; wr_data[0] = 8'hEE;
    @(negedge clk);
    check("start_in_done_ignored", 32'(busy[0]), 32'd0);
    start[0] = 1'b0;
    rv = rand_vec(0);
    do_vec(rv, 1'b0);

    // reset in the middle of bit 4
    @(negedge clk);
    do_cap[0] = 1'b0; do_upd[0] = 1'b1; wr_data[0] = 8'hE7; start[0] = 1'b1; mon_clr[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0; mon_clr[0] = 1'b0;
    repeat (17) @(negedge clk);
    check("busy_before_reset", 32'(busy[0]), 32'd1);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check("midreset_busy_done", 32'({busy[0], done[0]}), 32'd0);
    check("midreset_rd_data", 32'(rd_data0), 32'd0);
    check("midreset_scan_pins", 32'({clk1[0], clk2[0], scan_in[0], capture[0], update[0]}), 32'd0);
    repeat (3) @(negedge clk);
    check("midreset_stays_idle", 32'(busy[0]), 32'd0);
    check("midreset_no_update", 32'(upd_cyc[0]), 32'd0);
    rv = rand_vec(0);
    rv.pre_en = 1'b1; rv.pre = 8'h96; rv.cap = 1'b0; rv.exp_rd = 8'h96;
    rv.exp_lat = 4 * N + (rv.upd ? 1 : 0) + 1;
    do_vec(rv, 1'b0);

`ifdef SCAN_MASTER_LOOPBACK_CHECK_EN
    rv = '{1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h5A, 8'h00, 97};
    rv.exp_rd = exp_chain[1];
    do_vec(rv, 1'b0);
    rv.exp_rd = 8'h5A;
    do_vec(rv, 1'b0);
    check("loopback_clean", 32'(chk_err[1]), 32'd0);
    rv.pre_en = 1'b1; rv.pre = 8'h5B; rv.exp_rd = 8'h5B;
    do_vec(rv, 1'b0);
    check("loopback_bitflip", 32'(chk_err[1]), 32'd1);
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scan_chain_master.md
Name: scan_chain_master

Overview:
- Tester-side driver for the two-phase scan chain that fronts the small_kyber test harness.
- Accepts a parallel word on a single system clock and serialises it into the chain:
  - generates non-overlapping clk1/clk2, scan_in, capture and update;
  - collects scan_out back into a parallel read word.
- Used on-chip or in FPGA test wrappers so software can load message/encr_message/genmat_message/read_addr and read read_data1..3 without bit-banging.

Parameters:
- NUM_SCAN_BITS, 523, chain length in bits.
- PHASE, 1, system-clock cycles per scan phase (≥1).
- CNT_W, 10, bit-counter width; must satisfy 2^CNT_W > NUM_SCAN_BITS.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- do_capture  in  1  sampled with start; 1 = capture par_in before shifting.
- do_update  in  1  sampled with start; 1 = pulse update after shifting.
- wr_data  in  NUM_SCAN_BITS  word to load; latched on accepted start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the operation completes.
- rd_data  out  NUM_SCAN_BITS  word shifted out of the chain; valid when done.
- clk1  out  1  scan master-latch clock.
- clk2  out  1  scan slave-latch clock.
- scan_in  out  1  serial data to chain.
- capture  out  1  chain parallel-capture select.
- update  out  1  chain shadow-register update strobe.
- scan_out  in  1  serial data from chain.

Behaviour:
- Chain convention: scan_in enters bit NUM_SCAN_BITS-1; scan_out = bit 0. The word is therefore sent LSB first: wr_data[0] first, wr_data[N-1] last. rd_data is assembled the same way: first sampled bit goes to rd_data[0].
- Reset (any state, including mid-operation): next cycle state = IDLE and all outputs 0 (busy, done, clk1, clk2, scan_in, capture, update, rd_data). No partial update pulse is ever issued.
- States:
  - IDLE:
    - start=1 latches wr_data into the shift register, latches do_capture/do_update, clears the bit counter and the phase timer.
    - Next state is CAP if do_capture=1, else SETUP.
  - CAP (4*PHASE cycles):
    - capture=1 throughout.
    - clk1=1 during sub-phase 1 and clk2=1 during sub-phase 3; sub-phases 0 and 2 have both clocks low.
    - Not counted as a shift.
  - SETUP (PHASE cycles):
    - scan_in = current shift_reg[0].
    - On the last cycle, scan_out is sampled into the rd shift register (shift right, insert at MSB).
  - C1 (PHASE cycles): clk1=1.
  - GAP (PHASE cycles): clk1=0, clk2=0.
  - C2 (PHASE cycles): clk2=1.
    - On the last cycle, the wr shift register shifts right and the counter increments.
    - If counter = NUM_SCAN_BITS-1, go to UPD when do_update=1, else DONE. Otherwise go to SETUP.
  - UPD (PHASE cycles): update=1, clocks low.
  - DONE (1 cycle): done=1, busy=0; return to IDLE.
- Invariants:
  - clk1 and clk2 are never high in the same cycle.
  - A clock edge and a scan_in change never occur in the same cycle.
  - scan_in is stable from SETUP through C2.
- Latency, start accepted to done high:
  - (do_capture ? 4*PHASE : 0) + 4*PHASE*NUM_SCAN_BITS + (do_update ? PHASE : 0) + 1 cycles.
- Concurrent requests:
  - start while busy is ignored.
  - start in the DONE cycle is ignored.
  - start in the first IDLE cycle after DONE is accepted.
- Output hold:
  - rd_data holds its value until the next accepted start; it is updated only at DONE.
  - Intermediate rd_data values are not exposed.
- scan_in holds its last driven value between bits and returns to 0 in IDLE.

Optional Feature:
- Macro: SCAN_MASTER_LOOPBACK_CHECK_EN.
- Defined:
  - Adds output port chk_err (1 bit).
  - At DONE, chk_err = 1 if rd_data differs from the wr_data of the previous operation; it holds until the next start, and the reset value is 0.
  - The first operation after reset reports chk_err = 0.
  - Intended for the shift-twice chain-integrity test.
- Undefined: no chk_err port and no comparison logic.

Test Plan:
- NUM_SCAN_BITS=8, PHASE=1, do_capture=0, do_update=1, wr_data=8'hA5 → done asserted 34 cycles after start; chain model holds 8'hA5; exactly one update pulse of 1 cycle; clk1/clk2 never overlap.
- Same setup, chain preloaded with 8'h3C, do_update=0 → rd_data=8'h3C; done 33 cycles after start; update stays 0 throughout.
- do_capture=1, chain par_in=8'hF0, wr_data=8'h00 → capture high exactly 4 cycles with one clk1 and one clk2 pulse; rd_data=8'hF0; done 37 cycles after start.
- PHASE=3, wr_data=8'h81 → every clk1/clk2 high time is 3 cycles; scan_in sequence 1,0,0,0,0,0,0,1; total 97+3=100 cycles with do_update=1.
- Assert rst at bit 4 of a shift → next cycle all outputs 0 and state IDLE; no update pulse; a new start then completes normally.
- start pulsed while busy and in the DONE cycle → ignored. With SCAN_MASTER_LOOPBACK_CHECK_EN: shift 8'h5A twice then gives chk_err=0; inject a bit flip in the chain model then gives chk_err=1.
